// File: rtl/prio_disp_pkg.sv
// Shared definitions for the priority-scan display: mode encodings,
// the gfedcba hex segment table and small elaboration-time helpers.
package prio_disp_pkg;

  localparam logic [1:0] MODE_LIVE_HI = 2'b00;
  localparam logic [1:0] MODE_PEAK    = 2'b01;
  localparam logic [1:0] MODE_STROBE  = 2'b10;
  localparam logic [1:0] MODE_LIVE_LO = 2'b11;

  // Active-high segment patterns, bit order gfedcba, indexed by nibble value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to seven-segment decoder (gfedcba, active-high).
module hex_to_7seg
  import prio_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/prio_scan_display.sv
// Priority encoder over a registered request vector with live, peak-hold and
// strobed result modes, driving a multiplexed hex seven-segment display.
module prio_scan_display
  import prio_disp_pkg::*;
#(
  parameter  int N_IN     = 16,
  parameter  int SCAN_DIV = 1000,
  localparam int IDX_W    = max_int(1, clog2(N_IN)),
  localparam int NDIG     = (IDX_W + 3) / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  data,
  input  logic [1:0]       mode,
  input  logic             capture,
  input  logic             clear,
  output logic [IDX_W-1:0] index,
  output logic             valid,
  output logic [6:0]       segments,
  output logic             none,
  output logic [NDIG-1:0]  digit_en
);

  localparam int CNT_W = max_int(1, clog2(SCAN_DIV));
  localparam int SEL_W = max_int(1, clog2(NDIG));
  localparam int EXT_W = 4 * NDIG;

  logic [N_IN-1:0]  sample;
  logic [IDX_W-1:0] hi;
  logic [IDX_W-1:0] lo;
  logic             any;

  logic [IDX_W-1:0] index_nxt;
  logic             valid_nxt;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] sel_nxt;

  logic [EXT_W-1:0] index_ext;
  logic [3:0]       nibble;
  logic [6:0]       seg_pat;

  // Encoder: later iterations override earlier ones, so the loop direction
  // decides whether the highest or lowest set bit wins.
  always_comb begin
    hi = '0;
    lo = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (sample[i]) hi = IDX_W'(i);
    end
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (sample[i]) lo = IDX_W'(i);
    end
  end

  assign any = |sample;

  // NOTE: every variable gets a default at the top of an always_comb so an
  // unhandled branch holds state in a flop, never in an inferred latch.
  always_comb begin
    index_nxt = index;
    valid_nxt = valid;
    case (mode)
      MODE_LIVE_HI: begin
        index_nxt = hi;
        valid_nxt = any;
      end
      MODE_LIVE_LO: begin
        index_nxt = lo;
        valid_nxt = any;
      end
      MODE_PEAK: begin
        if (clear) begin
          index_nxt = '0;
          valid_nxt = 1'b0;
        end else if (any && (!valid || hi > index)) begin
          index_nxt = hi;
          valid_nxt = 1'b1;
        end
      end
      MODE_STROBE: begin
        if (clear) begin
          index_nxt = '0;
          valid_nxt = 1'b0;
        end else if (capture) begin
          index_nxt = hi;
          valid_nxt = any;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    sel_nxt = sel;
    if (cnt == CNT_W'(SCAN_DIV - 1)) begin
      cnt_nxt = '0;
      sel_nxt = (sel == SEL_W'(NDIG - 1)) ? '0 : sel + SEL_W'(1);
    end
  end

  // Segments are decoded from the next index and next digit select so that
  // they, digit_en and index all change on the same edge.
  assign index_ext = EXT_W'(index_nxt);

  always_comb begin
    nibble = '0;
    for (int d = 0; d < NDIG; d++) begin
      if (sel_nxt == SEL_W'(d)) nibble = index_ext[4*d +: 4];
    end
  end

  hex_to_7seg u_hex (
    .nibble (nibble),
    .seg    (seg_pat)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample   <= '0;
      index    <= '0;
      valid    <= 1'b0;
      cnt      <= '0;
      sel      <= '0;
      segments <= '0;
      digit_en <= NDIG'(1);
    end else begin
      sample   <= data;
      index    <= index_nxt;
      valid    <= valid_nxt;
      cnt      <= cnt_nxt;
      sel      <= sel_nxt;
      segments <= valid_nxt ? seg_pat : 7'b0000000;
      digit_en <= NDIG'(1) << sel_nxt;
    end
  end

  assign none = ~valid;

endmodule
